// File: rtl/serial_addsub_pkg.sv
// Shared types and default sizing for the chunk-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/serial_addsub_chunk_adder.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB for overflow detection.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        // The MSB sum bit is a^b^carry_in, so the incoming carry can be recovered from it.
        cmsb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, NCHUNK cycles per operation.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
    localparam int KW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    if (CHUNK < 1 || WIDTH < 2 || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
    end

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_q, b_q, s_q, s_next;
    logic [KW-1:0]     k;
    logic              carry;
    logic [CHUNK-1:0]  chunk_a, chunk_b, chunk_sum;
    logic              chunk_cout, chunk_cmsb;
    logic              last_chunk;

    assign last_chunk = (k == K_LAST);

    always_comb begin
        chunk_a = a_q[int'(k)*CHUNK +: CHUNK];
        chunk_b = b_q[int'(k)*CHUNK +: CHUNK];
        s_next  = s_q;
        s_next[int'(k)*CHUNK +: CHUNK] = chunk_sum;
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout),
        .cmsb (chunk_cmsb)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Subtraction is folded in at capture: B is stored inverted and the carry starts at !ci.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            k     <= '0;
            carry <= 1'b0;
            co    <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= ci ^ sub;
                        k     <= '0;
                    end
                end
                RUN: begin
                    s_q   <= s_next;
                    carry <= chunk_cout;
                    k     <= k + 1'b1;
                    if (last_chunk) begin
                        co   <= chunk_cout;
                        ovf  <= chunk_cmsb ^ chunk_cout;
                        zero <= (s_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s = s_q;

endmodule
